vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side consumer of the sprite/HUD renderer's pixel stream: generates 640x480@60 raster timing and drives `current_pixel_x`/`current_pixel_y` to the renderer.
- Samples the renderer's registered 8-bit RRRGGGBB `pixel_data` after a fixed pipeline delay and expands it to 8-bit-per-channel VGA DAC outputs, with syncs and blanking aligned to the delayed colour.
- Sits between the renderer and the board VGA pins, one instance in the top level.

Parameters:
- `CLK_DIV`, 2: `clk` cycles per pixel (50 MHz `clk` gives a 25 MHz pixel rate); even, 2 or more.
- `PIPE_LATENCY`, 2: `clk` cycles from a coordinate change to valid `pixel_data` (ROM read plus renderer output register); 1 to 4.
- `BG_COLOR`, 8'h00: RRRGGGBB value substituted when `pixel_data` equals the transparent key.
- `TRANSPARENT_KEY`, 8'hE3: renderer's transparent colour.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `pixel_data` input 8: RRRGGGBB from the renderer.
- `current_pixel_x` output 10: horizontal counter, 0..799.
- `current_pixel_y` output 10: vertical counter, 0..524.
- `vga_r` output 8: red DAC.
- `vga_g` output 8: green DAC.
- `vga_b` output 8: blue DAC.
- `vga_hs` output 1: horizontal sync, active low.
- `vga_vs` output 1: vertical sync, active low.
- `vga_blank_n` output 1: high during visible area.
- `vga_sync_n` output 1: constant 0.
- `vga_clk` output 1: pixel clock to the DAC.
- `frame_tick` output 1: one-`clk` pulse at frame start.

Behaviour:
- **Reset** (synchronous; `rst` high at a rising edge):
  - `div_cnt`, `h_cnt` and `v_cnt` clear to 0.
  - Delay line clears to the inactive state (hs=1, vs=1, de=0).
  - Outputs: `vga_r`/`vga_g`/`vga_b`=0, `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0, `vga_clk`=0, `frame_tick`=0.
  - `current_pixel_x`/`current_pixel_y` read 0 in the cycle after reset.
  - Asserting reset mid-frame restarts the raster at (0,0); no partial sync pulse is extended.
- **Pixel divider:**
  - `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - `pix_tick` = (`div_cnt` == `CLK_DIV`-1).
  - `vga_clk` is registered: low while `div_cnt` < `CLK_DIV`/2, high otherwise.
- **Counters**, advancing only on `pix_tick`:
  - `h_cnt` 0..799, wraps to 0.
  - On the `h_cnt` wrap, `v_cnt` increments 0..524 and wraps to 0.
  - `current_pixel_x` = `h_cnt`, `current_pixel_y` = `v_cnt`, driven directly from the registers and held for `CLK_DIV` clocks.
- **Raw timing**, combinational from the counters:
  - de = `h_cnt` < 640 and `v_cnt` < 480.
  - hs = not(656 ≤ `h_cnt` ≤ 751).
  - vs = not(490 ≤ `v_cnt` ≤ 491).
- **Alignment:**
  - hs/vs/de pass through a `PIPE_LATENCY`-stage shift register clocked every `clk`, not on `pix_tick`.
  - The output register stage samples the delayed signals and `pixel_data` at the same edge.
  - Total latency from a counter value to the VGA pins is `PIPE_LATENCY`+1 `clk` cycles.
- **Colour path** (registered):
  - c = (`pixel_data` == `TRANSPARENT_KEY`) ? `BG_COLOR` : `pixel_data`.
  - `vga_r` = {c[7:5], c[7:5], c[7:6]}.
  - `vga_g` = {c[4:2], c[4:2], c[4:3]}.
  - `vga_b` = {c[1:0], c[1:0], c[1:0], c[1:0]}.
  - When delayed de = 0, all three channels are 0 regardless of `pixel_data`.
  - `vga_blank_n` = delayed de.
- **`frame_tick`:** registered pulse for exactly one `clk`, on the edge where `pix_tick` wraps both counters to (0,0). It is not delayed.
- **Boundaries:**
  - `h_cnt`=799 and `v_cnt`=524 wrap together on one tick.
  - A frame is 800×525×`CLK_DIV` clocks.
  - `pixel_data` arriving outside de is ignored.

Optional Feature:
- Macro `SCANOUT_TEST_PATTERN_EN`.
- **When defined:**
  - Adds an input port `test_pattern` (1 bit).
  - While `test_pattern` is high, c is replaced by eight vertical 80-pixel colour bars: bar n = `h_cnt`[9:0]/80, delay-aligned with de.
  - Bar colour sequence: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - `pixel_data` and the transparent substitution are bypassed.
- **When undefined:** no port is added and the colour path is exactly as above.

Test Plan:
- Reset then release, `pixel_data`=8'hE0 constant → after reset `vga_hs`=1, `vga_vs`=1, `vga_r`=0; at the first visible pixel `vga_r`=8'hFF, `vga_g`=0, `vga_b`=0, appearing `PIPE_LATENCY`+1=3 clks after `current_pixel_x`=0.
- Line timing → `vga_hs` low for exactly 96×2=192 clks, each line 1600 clks; `vga_blank_n` high for 1280 clks per visible line.
- Frame timing → `vga_vs` low for 2 lines (3200 clks); `frame_tick` pulses every 840000 clks, one clk wide, coincident with `current_pixel_x`=0, `current_pixel_y`=0.
- `pixel_data`=8'hE3 with `BG_COLOR`=8'h1C → `vga_r`=0, `vga_g`=8'hFF, `vga_b`=0 in the visible area; `pixel_data`=8'hFF during `h_cnt` 640..799 → all channels 0.
- Latency: pixel_data=8'h03 for exactly one pixel period, aligned so the renderer would produce it for `h_cnt`=100 (i.e. `PIPE_LATENCY` clks after `current_pixel_x`=100) → `vga_b`=8'hFF only for the pins' pixel 100 window, neighbours 0.
- `rst` pulsed at `h_cnt`=700 (inside hsync) → the next cycle `vga_hs`=1, counters at 0, and the following hsync occurs at `h_cnt`=656 of the new line.

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: raster counters, sync/blank timing, RRRGGGBB expansion.
// Ports: clk, rst (sync, active-high), pixel_data in; pixel coords, VGA pins, frame_tick out.
// Optional: SCANOUT_TEST_PATTERN_EN adds input test_pattern (colour bars).
module vga_scanout #(
  parameter int          CLK_DIV         = 2,
  parameter int          PIPE_LATENCY    = 2,
  parameter logic [7:0]  BG_COLOR        = 8'h00,
  parameter logic [7:0]  TRANSPARENT_KEY = 8'hE3
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic       test_pattern,
`endif
  input  logic [7:0] pixel_data,
  output logic [9:0] current_pixel_x,
  output logic [9:0] current_pixel_y,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       frame_tick
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  typedef struct packed {
`ifdef SCANOUT_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
    logic hs;
    logic vs;
    logic de;
  } tm_t;

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic          pix_tick;
  logic          h_last;
  logic          v_last;

  tm_t raw;
  tm_t tail;
  tm_t dly [PIPE_LATENCY];

  logic [7:0] c;

  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_last   = (h_cnt == 10'd799);
  assign v_last   = (v_cnt == 10'd524);

  assign current_pixel_x = h_cnt;
  assign current_pixel_y = v_cnt;
  assign vga_sync_n      = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      vga_clk    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= pix_tick ? '0 : div_cnt + 1'b1;
      vga_clk    <= (div_cnt >= DIV_HALF);
      frame_tick <= pix_tick && h_last && v_last;
      if (pix_tick) begin
        h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
        if (h_last)
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  function automatic logic [2:0] bar_of(input logic [9:0] h);
    bar_of = 3'd7;
    for (int n = 7; n >= 1; n--)
      if (h < 10'(80 * n))
        bar_of = 3'(n - 1);
  endfunction

  function automatic logic [7:0] bar_color(input logic [2:0] b);
    unique case (b)
      3'd0: bar_color = 8'hFF;
      3'd1: bar_color = 8'hFC;
      3'd2: bar_color = 8'h1F;
      3'd3: bar_color = 8'h1C;
      3'd4: bar_color = 8'hE3;
      3'd5: bar_color = 8'hE0;
      3'd6: bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  endfunction
`endif

  always_comb begin
    raw    = '0;
    raw.de = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    raw.hs = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    raw.vs = !((v_cnt >= 10'd490) && (v_cnt <= 10'd491));
`ifdef SCANOUT_TEST_PATTERN_EN
    raw.bar = bar_of(h_cnt);
`endif
  end

  // Runs every clk so timing tracks the renderer's clk-based latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        dly[i]    <= '0;
        dly[i].hs <= 1'b1;
        dly[i].vs <= 1'b1;
      end
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < PIPE_LATENCY; i++)
        dly[i] <= dly[i-1];
    end
  end

  assign tail = dly[PIPE_LATENCY-1];

  always_comb begin
    c = (pixel_data == TRANSPARENT_KEY) ? BG_COLOR : pixel_data;
`ifdef SCANOUT_TEST_PATTERN_EN
    if (test_pattern)
      c = bar_color(tail.bar);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_hs      <= tail.hs;
      vga_vs      <= tail.vs;
      vga_blank_n <= tail.de;
      if (tail.de) begin
        vga_r <= {c[7:5], c[7:5], c[7:6]};
        vga_g <= {c[4:2], c[4:2], c[4:3]};
        vga_b <= {c[1:0], c[1:0], c[1:0], c[1:0]};
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout (BG_COLOR=1C, other parameters default).
// Frame-end cases jump v_cnt forward to keep the run short.
module tb_vga_scanout;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pd;
  logic [9:0] x, y;
  logic [7:0] r, g, b;
  logic       hs, vs, blank_n, sync_n, vclk, ft;

  int checks = 0;
  int errors = 0;
  int n, lo, hi, n2;

  localparam int S_HS = 0;
  localparam int S_VS = 1;
  localparam int S_BL = 2;
  localparam int S_FT = 3;
  localparam int S_X700 = 4;

  always #5 clk = ~clk;

  vga_scanout #(
    .BG_COLOR(8'h1C)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef SCANOUT_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .pixel_data(pd),
    .current_pixel_x(x),
    .current_pixel_y(y),
    .vga_r(r),
    .vga_g(g),
    .vga_b(b),
    .vga_hs(hs),
    .vga_vs(vs),
    .vga_blank_n(blank_n),
    .vga_sync_n(sync_n),
    .vga_clk(vclk),
    .frame_tick(ft)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_HS:   sig = hs;
      S_VS:   sig = vs;
      S_BL:   sig = blank_n;
      S_FT:   sig = ft;
      S_X700: sig = (x == 10'd700);
      default: sig = 1'b0;
    endcase
  endfunction

  task automatic wait_level(input string tag, input int sel,
                            input logic val, input int budget,
                            output int cnt);
    cnt = 0;
    while (sig(sel) !== val && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check(tag, 32'(sig(sel)), 32'(val));
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pd  = 8'hE0;
    step(3);
    check("rst_hs", 32'(hs), 1);
    check("rst_vs", 32'(vs), 1);
    check("rst_r", 32'(r), 0);
    check("rst_blank", 32'(blank_n), 0);
    check("rst_vclk", 32'(vclk), 0);
    check("rst_ft", 32'(ft), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("sync_n", 32'(sync_n), 0);
    rst = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blank_n && n < 20);
    check("first_lat", n, 3);
    check("first_r", 32'(r), 32'hFF);
    check("first_g", 32'(g), 0);
    check("first_b", 32'(b), 0);
    check("first_x", 32'(x), 1);
    check("vclk_lo", 32'(vclk), 0);
    step(1);
    check("vclk_hi", 32'(vclk), 1);

    pd = 8'h00;
    n = 0;
    while (x != 10'd100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    step(2);
    check("lat_pre", 32'(b), 0);
    pd = 8'h03;
    step(1);
    check("lat_p0", 32'(b), 32'hFF);
    step(1);
    check("lat_p1", 32'(b), 32'hFF);
    pd = 8'h00;
    step(1);
    check("lat_post", 32'(b), 0);

    pd = 8'hE3;
    step(2);
    check("key_r", 32'(r), 0);
    check("key_g", 32'(g), 32'hFF);
    check("key_b", 32'(b), 0);

    wait_level("hblank", S_BL, 1'b0, 2000, n);
    pd = 8'hFF;
    step(1);
    check("hbl_r", 32'(r), 0);
    check("hbl_g", 32'(g), 0);
    check("hbl_b", 32'(b), 0);

    wait_level("bl_rise", S_BL, 1'b1, 2000, n);
    wait_level("bl_fall", S_BL, 1'b0, 2000, hi);
    check("blank_len", hi, 1280);
    wait_level("hs_fall", S_HS, 1'b0, 2000, n);
    wait_level("hs_rise", S_HS, 1'b1, 2000, lo);
    check("hs_len", lo, 192);
    wait_level("hs_fall2", S_HS, 1'b0, 2000, n2);
    check("line_len", lo + n2, 1600);

    wait_level("at_x700", S_X700, 1'b1, 2000, n);
    check("mid_hs", 32'(hs), 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mr_hs", 32'(hs), 1);
    check("mr_x", 32'(x), 0);
    check("mr_y", 32'(y), 0);
    check("mr_blank", 32'(blank_n), 0);
    check("mr_r", 32'(r), 0);
    wait_level("mr_hs_fall", S_HS, 1'b0, 3000, n);
    check("mr_hs_at", n, 1315);

    dut.v_cnt = 10'd489;
    wait_level("vs_fall", S_VS, 1'b0, 4000, n);
    wait_level("vs_rise", S_VS, 1'b1, 5000, lo);
    check("vs_len", lo, 3200);

    dut.v_cnt = 10'd523;
    wait_level("ft_rise", S_FT, 1'b1, 4000, n);
    check("ft_x", 32'(x), 0);
    check("ft_y", 32'(y), 0);
    step(1);
    check("ft_width", 32'(ft), 0);
    check("ft_x_hold", 32'(x), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
